// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Single-neuron multiply-accumulate stage. Streams one signed
//               sample per valid cycle, drives the weight memory read port
//               with the matching address, accumulates weight*sample products
//               in full precision and, after NUM_WEIGHTS samples, adds the
//               bias, applies ReLU and saturation and emits one activation.
//
// Ports       : clk           - clock, rising edge active
//               reset_n       - asynchronous active-low reset
//               i_data_valid  - input sample valid (no backpressure)
//               i_data        - signed input sample
//               i_bias        - signed bias, held stable by the system
//               o_r_en        - weight memory read enable (= i_data_valid)
//               o_r_addr      - weight memory read address (sample counter)
//               i_w_data      - weight, valid one cycle after o_r_en
//               o_out_valid   - one-cycle pulse qualifying o_out
//               o_out         - activation, holds value between pulses
//
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
    parameter int NUM_WEIGHTS = 784,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic                  o_r_en,
    output logic [ADDR_WIDTH-1:0] o_r_addr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out
);

    localparam int c_prod_w = 2 * DATA_WIDTH;
    localparam int c_acc_w  = c_prod_w + ADDR_WIDTH;
    // One guard bit above the accumulator so adding the bias cannot wrap.
    localparam int c_sum_w  = c_acc_w + 1;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
    localparam logic signed [c_sum_w-1:0] c_sat_max =
        {{(c_sum_w - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

    // Sample counter doubles as the weight read address.
    logic [ADDR_WIDTH-1:0] r_cnt;

    // Stage 0: delayed sample and flags, aligned with the memory read.
    logic                  r_s0_valid;
    logic                  r_s0_first;
    logic                  r_s0_last;
    logic [DATA_WIDTH-1:0] r_s0_data;

    // Stage 1: registered product.
    logic                       r_s1_valid;
    logic                       r_s1_first;
    logic                       r_s1_last;
    logic signed [c_prod_w-1:0] r_s1_prod;

    // Stage 2: accumulator and "frame complete" marker.
    logic signed [c_acc_w-1:0] r_acc;
    logic                      r_s2_last;

    // Stage 3: output register.
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out;

    logic signed [c_prod_w-1:0] w_w_ext;
    logic signed [c_prod_w-1:0] w_d_ext;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_prod_ext;
    logic signed [c_sum_w-1:0]  w_bias_ext;
    logic signed [c_sum_w-1:0]  w_sum;
    logic signed [c_sum_w-1:0]  w_shifted;
    logic [DATA_WIDTH-1:0]      w_result;

    assign o_r_en      = i_data_valid;
    assign o_r_addr    = r_cnt;
    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;

    // ------------------------------------------------------------------
    // Sample counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_data_valid) begin
            r_cnt <= (r_cnt == c_last_addr) ? '0 : r_cnt + c_addr_one;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: capture sample and frame-position flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s0_valid <= 1'b0;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_data  <= '0;
        end else begin
            r_s0_valid <= i_data_valid;
            r_s0_first <= i_data_valid && (r_cnt == '0);
            r_s0_last  <= i_data_valid && (r_cnt == c_last_addr);
            if (i_data_valid) begin
                r_s0_data <= i_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: full-precision signed product
    // ------------------------------------------------------------------
    // Operands are sign-extended to the product width so the low c_prod_w
    // bits of the multiply are the exact signed product.
    assign w_w_ext = {{DATA_WIDTH{i_w_data[DATA_WIDTH-1]}}, i_w_data};
    assign w_d_ext = {{DATA_WIDTH{r_s0_data[DATA_WIDTH-1]}}, r_s0_data};
    assign w_prod  = w_w_ext * w_d_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_prod  <= '0;
        end else begin
            r_s1_valid <= r_s0_valid;
            r_s1_first <= r_s0_valid && r_s0_first;
            r_s1_last  <= r_s0_valid && r_s0_last;
            if (r_s0_valid) begin
                r_s1_prod <= w_prod;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate; a "first" product restarts the sum so frames
    // can run back to back without a clear cycle.
    // ------------------------------------------------------------------
    assign w_prod_ext = {{ADDR_WIDTH{r_s1_prod[c_prod_w-1]}}, r_s1_prod};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_s2_last <= 1'b0;
        end else begin
            r_s2_last <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_acc <= r_s1_first ? w_prod_ext : r_acc + w_prod_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: bias, ReLU, rescale and saturate. Reads r_acc before the
    // edge, so a new frame loading the accumulator on the same edge is safe.
    // ------------------------------------------------------------------
    assign w_bias_ext = {{(c_sum_w - DATA_WIDTH){i_bias[DATA_WIDTH-1]}}, i_bias};
    assign w_sum      = {r_acc[c_acc_w-1], r_acc} + (w_bias_ext <<< FRAC_BITS);
    assign w_shifted  = w_sum >>> FRAC_BITS;

    always_comb begin
        w_result = '0;
        if (w_sum[c_sum_w-1]) begin
            w_result = '0;
        end else if (w_shifted > c_sat_max) begin
            w_result = c_sat_max[DATA_WIDTH-1:0];
        end else begin
            w_result = w_shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_out_valid <= r_s2_last;
            if (r_s2_last) begin
                r_out <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate stage that sits directly downstream of the weight `memory` block. It streams one input sample per valid cycle and drives the memory read port with the matching weight address. Each weight/sample product is accumulated in full precision. After `NUM_WEIGHTS` samples it adds the bias, applies ReLU and saturation, and emits one fixed-point activation to the next layer.

## Interface
- `NUM_WEIGHTS`, 784: samples per frame; must equal the weight memory `MEM_DEPTH`.
- `ADDR_WIDTH`, 10: weight address width; requires 2^ADDR_WIDTH ≥ NUM_WEIGHTS.
- `DATA_WIDTH`, 16: width of signed two's-complement sample, weight, bias and output.
- `FRAC_BITS`, 12: fractional bits of the fixed-point format (default Q4.12).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_data_valid`  in  1  input sample valid; no backpressure.
- `i_data`  in  DATA_WIDTH  signed input sample.
- `i_bias`  in  DATA_WIDTH  signed bias; held stable by the system.
- `o_r_en`  out  1  weight memory read enable; combinational, equal to `i_data_valid`.
- `o_r_addr`  out  ADDR_WIDTH  weight memory read address; registered sample counter.
- `i_w_data`  in  DATA_WIDTH  weight from memory `o_data_out`, valid one cycle after `o_r_en`.
- `o_out_valid`  out  1  one-cycle pulse; `o_out` is valid while it is high.
- `o_out`  out  DATA_WIDTH  activation; holds its last value between pulses.

## Operation
- The sample counter `cnt` is `o_r_addr`. On each valid edge it advances: it goes from NUM_WEIGHTS-1 to 0, otherwise +1. It holds when `i_data_valid` is low.
- Flags are tagged at the valid edge and travel with the sample down the pipeline:
  - `first` = (cnt==0).
  - `last` = (cnt==NUM_WEIGHTS-1).
- Stage 0, valid edge: capture `i_data`, valid, `first` and `last` into the delay registers. The memory latches the weight on the same edge.
- Stage 1: compute `i_w_data` × delayed sample as a signed 2·DATA_WIDTH-bit product. Register the product and its flags.
- Stage 2: the accumulator is ACC_W = 2·DATA_WIDTH + ADDR_WIDTH bits, signed.
  - A product tagged `first` loads the accumulator with the product.
  - Any other product is added to the accumulator.
  - The accumulator never wraps for in-range operands.
- Stage 3: one cycle after a `last` product is accumulated:
  - Sum = acc + (sign-extended `i_bias` << FRAC_BITS).
  - If sum < 0, the result is 0 (ReLU).
  - Otherwise the result is sum >>> FRAC_BITS, truncated. It saturates to 2^(DATA_WIDTH-1)-1 if it exceeds that value.
  - The result is registered to `o_out`, and `o_out_valid` pulses for one cycle.
- Frames may run back to back with no gap. The stage-3 read of the old accumulator and the stage-2 `first` load of the new frame happen on the same edge; stage 3 uses the pre-edge value.
- Gaps in `i_data_valid` anywhere in a frame are allowed. Bubbles propagate through the pipeline and do not change the accumulator.
- There is no frame abort other than reset.

## Timing
- Reset (asynchronous, immediate) clears:
  - `cnt`, so `o_r_addr`=0.
  - All pipeline valid and flag bits.
  - The accumulator and `o_out`, both to 0.
  - `o_out_valid`, to 0.
- `o_r_en` stays combinational from `i_data_valid` during reset.
- Latency: the last sample is sampled at edge E0, and `o_out_valid` is high for the cycle after edge E3, i.e. E0 + 3 edges.
- Throughput: one sample per cycle, one output per NUM_WEIGHTS valid samples.
- Reset mid-frame discards the partial sum. The next valid sample is treated as address 0.
- `i_w_data` is sampled only in the cycle after `o_r_en` is high; all other values are ignored.

## Test plan
Bench settings: NUM_WEIGHTS=3, Q4.12, behavioural memory model with 1-cycle read latency.
- Basic sum: weights 0x1000×3, inputs 0x1000, 0x2000, 0x0800, bias 0 → `o_r_addr` 0, 1, 2; `o_out`=0x3800; `o_out_valid` high exactly 3 edges after the third valid edge.
- ReLU: weights 0xF000×3, inputs 0x1000×3, bias 0x0800 (sum −2.5) → `o_out`=0x0000, one pulse.
- Saturation: weights 0x7FFF×3, inputs 0x7FFF×3, bias 0x7FFF → `o_out`=0x7FFF.
- Back-to-back and gapped frames: frame A as in basic sum, contiguous with frame B (inputs 0x1000×3, bias 0x1000); then frame C with two idle cycles between its samples.
  - A → 0x3800, B → 0x4000, C correct.
  - Address sequence 0, 1, 2, 0, 1, 2, 0, 1, 2.
  - No cross-frame leakage.
- Mid-frame reset: assert `reset_n`=0 after 2 samples → `o_r_addr`=0, `o_out`=0, `o_out_valid`=0 immediately. A following basic-sum frame → 0x3800.
- Bias only: inputs 0x0000×3, bias 0x1800 → `o_out`=0x1800.
